// File: rtl/iface_rr_mux_pkg.sv
// -----------------------------------------------------------------------------
// iface_rr_mux_pkg
// Shared helpers for the round-robin channel merger.
//   width_t      : integer type returned by the width helpers
//   stat_t       : statistics counter word
//   STAT_W       : width of every statistics counter
//   clog2_min1() : ceil(log2(n)), never less than 1 (index widths)
//   ptr_width()  : FIFO pointer width, one extra bit to tell full from empty
// -----------------------------------------------------------------------------
package iface_rr_mux_pkg;

    localparam int STAT_W = 16;

    typedef int unsigned width_t;
    typedef logic [STAT_W-1:0] stat_t;

    function automatic width_t clog2_min1(input int n);
        width_t r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = width_t'(i + 1);
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic width_t ptr_width(input int depth);
        return clog2_min1(depth) + 1;
    endfunction

endpackage

// File: rtl/iface_chan_fifo.sv
// -----------------------------------------------------------------------------
// iface_chan_fifo
// Single-channel DEPTH x WIDTH FIFO with a combinational head so the arbiter
// can load its output register in the same cycle it pops.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   push, push_data  : write request / item (ignored while full)
//   pop              : read request (ignored while empty)
//   full, empty      : status from registered pointers only
//   head_data        : oldest buffered item
// -----------------------------------------------------------------------------
module iface_chan_fifo
    import iface_rr_mux_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    localparam int AW = int'(clog2_min1(DEPTH));
    localparam int PW = int'(ptr_width(DEPTH));

    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Pointers run modulo 2*DEPTH; the extra MSB distinguishes full from empty.
    assign empty     = (wr_ptr_reg == rd_ptr_reg);
    assign full      = (wr_ptr_reg[PW-1] != rd_ptr_reg[PW-1]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign head_data = mem[rd_ptr_reg[AW-1:0]];
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
        end
    end

    // Storage carries no reset: contents are only visible behind a valid pointer.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/iface_rr_mux.sv
// -----------------------------------------------------------------------------
// iface_rr_mux
// Merges NCHAN producer channels into one registered valid/ready consumer
// channel tagged with the source index. Each input has its own DEPTH FIFO;
// a round-robin arbiter picks the next non-empty FIFO whenever the output
// register is empty or being drained.
// Optional build macro: IFACE_RR_MUX_STATS_EN (adds grant_cnt / stall_cnt).
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid[NCHAN]       : per-channel producer valid
//   in_data[NCHAN*WIDTH]  : channel i at [i*WIDTH +: WIDTH]
//   in_ready[NCHAN]       : per-channel FIFO not full (registered state only)
//   out_valid/out_data    : consumer item
//   out_chan              : source channel of out_data
//   out_ready             : consumer accept
//   grant_cnt[NCHAN*16]   : (stats) saturating per-channel load count
//   stall_cnt[16]         : (stats) saturating count of out_valid && !out_ready
// -----------------------------------------------------------------------------
module iface_rr_mux
    import iface_rr_mux_pkg::*;
#(
    parameter  int WIDTH = 3,
    parameter  int DEPTH = 4,
    parameter  int NCHAN = 2,
    localparam int CHW   = int'(clog2_min1(NCHAN))
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCHAN-1:0]       in_valid,
    input  logic [NCHAN*WIDTH-1:0] in_data,
    output logic [NCHAN-1:0]       in_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [CHW-1:0]         out_chan,
    input  logic                   out_ready
`ifdef IFACE_RR_MUX_STATS_EN
    ,
    output logic [NCHAN*STAT_W-1:0] grant_cnt,
    output logic [STAT_W-1:0]       stall_cnt
`endif
);

    logic [NCHAN-1:0] fifo_full;
    logic [NCHAN-1:0] fifo_empty;
    logic [NCHAN-1:0] fifo_pop;
    logic [WIDTH-1:0] head_data [NCHAN];

    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic [CHW-1:0]   out_chan_reg;
    logic [CHW-1:0]   rr_reg;
    logic [CHW-1:0]   rr_next;
    logic [CHW-1:0]   win;
    logic             found;
    logic             load;
    int               cand;

    genvar gi;
    generate
        for (gi = 0; gi < NCHAN; gi++) begin : g_chan
            iface_chan_fifo #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk       (clk),
                .rst_n     (rst_n),
                .push      (in_valid[gi] && !fifo_full[gi]),
                .push_data (in_data[gi*WIDTH +: WIDTH]),
                .pop       (fifo_pop[gi]),
                .full      (fifo_full[gi]),
                .empty     (fifo_empty[gi]),
                .head_data (head_data[gi])
            );
            assign in_ready[gi] = !fifo_full[gi];
            assign fifo_pop[gi] = load && found && (win == CHW'(gi));
        end
    endgenerate

    always_comb begin
        load  = !out_valid_reg || out_ready;
        found = 1'b0;
        win   = '0;
        cand  = 0;
        // Offsets are walked high-to-low so the nearest non-empty channel at
        // or after rr_reg is the last one written, i.e. the winner.
        for (int k = NCHAN - 1; k >= 0; k--) begin
            cand = (int'(rr_reg) + k) % NCHAN;
            if (!fifo_empty[cand]) begin
                found = 1'b1;
                win   = CHW'(cand);
            end
        end
        rr_next = (int'(win) == NCHAN - 1) ? '0 : win + CHW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_chan_reg  <= '0;
            rr_reg        <= '0;
        end else if (load) begin
            if (found) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= head_data[win];
                out_chan_reg  <= win;
                rr_reg        <= rr_next;
            end else begin
                // Data and channel keep their last values; only valid drops.
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_chan  = out_chan_reg;

`ifdef IFACE_RR_MUX_STATS_EN
    stat_t grant_cnt_reg [NCHAN];
    stat_t stall_cnt_reg;

    generate
        for (gi = 0; gi < NCHAN; gi++) begin : g_stat
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    grant_cnt_reg[gi] <= '0;
                end else if (fifo_pop[gi] && (grant_cnt_reg[gi] != '1)) begin
                    grant_cnt_reg[gi] <= grant_cnt_reg[gi] + STAT_W'(1);
                end
            end
            assign grant_cnt[gi*STAT_W +: STAT_W] = grant_cnt_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
        end else if (out_valid_reg && !out_ready && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + STAT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule
